// File: rtl/ifu_pkg.sv
// Shared types and line geometry for the instruction-fetch fill path.
package ifu_pkg;

    localparam int CL_WIDTH     = 128;
    localparam int WORD_WIDTH   = 32;
    localparam int WORDS_PER_CL = CL_WIDTH / WORD_WIDTH;
    localparam int WORD_IDX_W   = $clog2(WORDS_PER_CL);
    localparam int CNT_W        = WORD_IDX_W + 1;
    localparam int LINE_BYTES   = CL_WIDTH / 8;

    typedef struct packed {
        logic [31:0] fill_requested_address;
        logic        valid;
    } t_cache2i_mem_req;

    typedef struct packed {
        logic [CL_WIDTH-1:0] filled_instruction;
        logic                valid;
        logic [31:0]         address;
    } t_i_mem2cache_rsp;

    typedef enum logic [1:0] {
        FILL_IDLE,
        FILL_FETCH,
        FILL_RESP
    } t_fill_states;

    function automatic logic [31:0] line_base(input logic [31:0] addr);
        return addr & ~32'(LINE_BYTES - 1);
    endfunction

endpackage

// File: rtl/ifu_line_fill.sv
// Cache-line fill engine: issues WORDS_PER_CL in-order word reads, assembles the
// returns into one line and hands it to the cache as a single-cycle response.
module ifu_line_fill
    import ifu_pkg::*;
(
    input  logic                  Clk,
    input  logic                  Rst,
    input  t_cache2i_mem_req      FillReq,
    output t_i_mem2cache_rsp      FillRsp,
    output logic                  MemRdEn,
    output logic [31:0]           MemRdAddr,
    input  logic                  MemRdReady,
    input  logic                  MemRdDataValid,
    input  logic [WORD_WIDTH-1:0] MemRdData,
    output logic                  FillBusy
);

    typedef logic [WORDS_PER_CL-1:0][WORD_WIDTH-1:0] t_line;

    t_fill_states     state_q,     state_d;
    logic [31:0]      base_q,      base_d;
    logic [CNT_W-1:0] issue_cnt_q, issue_cnt_d;
    logic [CNT_W-1:0] ret_cnt_q,   ret_cnt_d;
    t_line            line_q,      line_d;
    logic             rd_en_q,     rd_en_d;
    logic [31:0]      rd_addr_q,   rd_addr_d;
    logic             busy_q,      busy_d;
    t_i_mem2cache_rsp rsp_q,       rsp_d;

    always_comb begin
        // NOTE: every _d starts from its _q, so no path through the case can leave one unassigned and infer a latch.
        state_d     = state_q;
        base_d      = base_q;
        issue_cnt_d = issue_cnt_q;
        ret_cnt_d   = ret_cnt_q;
        line_d      = line_q;
        rd_en_d     = rd_en_q;
        rd_addr_d   = rd_addr_q;
        busy_d      = busy_q;
        rsp_d       = rsp_q;
        rsp_d.valid = 1'b0;

        case (state_q)
            FILL_IDLE: begin
                if (FillReq.valid) begin
                    state_d     = FILL_FETCH;
                    base_d      = line_base(FillReq.fill_requested_address);
                    issue_cnt_d = '0;
                    ret_cnt_d   = '0;
                    rd_en_d     = 1'b1;
                    rd_addr_d   = line_base(FillReq.fill_requested_address);
                    busy_d      = 1'b1;
                end
            end

            FILL_FETCH: begin
                // Next address is precomputed so MemRdAddr is a flop and stays put under back-pressure.
                if (rd_en_q && MemRdReady) begin
                    issue_cnt_d = issue_cnt_q + 1'b1;
                    rd_en_d     = issue_cnt_d < CNT_W'(WORDS_PER_CL);
                    if (rd_en_d) begin
                        rd_addr_d = base_q + (32'(issue_cnt_d) << 2);
                    end
                end
                if (MemRdDataValid) begin
                    line_d[ret_cnt_q[WORD_IDX_W-1:0]] = MemRdData;
                    ret_cnt_d = ret_cnt_q + 1'b1;
                    if (ret_cnt_q == CNT_W'(WORDS_PER_CL - 1)) begin
                        state_d                  = FILL_RESP;
                        rsp_d.valid              = 1'b1;
                        rsp_d.filled_instruction = line_d;
                        rsp_d.address            = base_q;
                    end
                end
            end

            FILL_RESP: begin
                state_d     = FILL_IDLE;
                issue_cnt_d = '0;
                ret_cnt_d   = '0;
                busy_d      = 1'b0;
            end

            default: begin
                state_d = FILL_IDLE;
                busy_d  = 1'b0;
                rd_en_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        // NOTE: non-blocking assignments so every flop samples the pre-edge value of all the others.
        if (Rst) begin
            state_q     <= FILL_IDLE;
            base_q      <= '0;
            issue_cnt_q <= '0;
            ret_cnt_q   <= '0;
            line_q      <= '0;
            rd_en_q     <= 1'b0;
            rd_addr_q   <= '0;
            busy_q      <= 1'b0;
            rsp_q       <= '0;
        end else begin
            state_q     <= state_d;
            base_q      <= base_d;
            issue_cnt_q <= issue_cnt_d;
            ret_cnt_q   <= ret_cnt_d;
            line_q      <= line_d;
            rd_en_q     <= rd_en_d;
            rd_addr_q   <= rd_addr_d;
            busy_q      <= busy_d;
            rsp_q       <= rsp_d;
        end
    end

    assign FillRsp   = rsp_q;
    assign MemRdEn   = rd_en_q;
    assign MemRdAddr = rd_addr_q;
    assign FillBusy  = busy_q;

endmodule

// File: tb/tb_ifu_line_fill.sv
// Directed bench for ifu_line_fill: table of fill scenarios plus hand-written reset and idle sequences.
module tb_ifu_line_fill;
    import ifu_pkg::*;

    logic                  Clk;
    logic                  Rst;
    t_cache2i_mem_req      fill_req;
    t_i_mem2cache_rsp      fill_rsp;
    logic                  mem_rd_en;
    logic [31:0]           mem_rd_addr;
    logic                  mem_rd_ready;
    logic                  mem_rd_data_valid;
    logic [WORD_WIDTH-1:0] mem_rd_data;
    logic                  fill_busy;

    int total = 0;
    int bad   = 0;

    ifu_line_fill dut (
        .Clk           (Clk),
        .Rst           (Rst),
        .FillReq       (fill_req),
        .FillRsp       (fill_rsp),
        .MemRdEn       (mem_rd_en),
        .MemRdAddr     (mem_rd_addr),
        .MemRdReady    (mem_rd_ready),
        .MemRdDataValid(mem_rd_data_valid),
        .MemRdData     (mem_rd_data),
        .FillBusy      (fill_busy)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic [31:0]        addr;
        logic [31:0]        alt_addr;     // nonzero: request address changes to this while busy
        logic [3:0][31:0]   data;         // word k returned k-th
        logic [3:0][7:0]    lat;          // cycles from accept to return, per word
        logic [7:0]         rdy;          // Ready pattern, bit (c-1)%8 in cycle c
        logic [31:0]        exp_base;
        logic [127:0]       exp_line;
        int                 exp_rsp_cyc;  // 0: not checked
        bit                 spurious_after;
        bit                 b2b_next;
    } fill_vec_t;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Runs one fill from the current negedge; leaves the request dropped one cycle after the response.
    task automatic run_fill(input fill_vec_t v);
        int   due [4];
        int   n_acc, n_ret, last_due, last_ret, rsp_cyc, rsp_cnt, hold_bad, extra_en, d;
        logic prev_en, prev_rdy, rdy;
        logic [31:0] prev_addr;
        bit   done;
        n_acc = 0; n_ret = 0; last_due = -1; last_ret = -100; rsp_cyc = -1; rsp_cnt = 0;
        hold_bad = 0; extra_en = 0; done = 0;
        prev_en = 1'b0; prev_rdy = 1'b0; prev_addr = '0;
        fill_req.fill_requested_address = v.addr;
        fill_req.valid    = 1'b1;
        mem_rd_ready      = 1'b0;
        mem_rd_data_valid = 1'b0;
        for (int c = 1; c <= 200 && !done; c++) begin
            @(negedge Clk);
            if (c == 1) check("rd_en_first_cycle", mem_rd_en, 1'b1);
            if (fill_rsp.valid) begin
                rsp_cnt++;
                if (rsp_cnt == 1) begin
                    rsp_cyc = c;
                    check("rsp_addr", fill_rsp.address, v.exp_base);
                    check("rsp_line", fill_rsp.filled_instruction, v.exp_line);
                end
            end
            if (prev_en && !prev_rdy && (!mem_rd_en || mem_rd_addr !== prev_addr)) hold_bad++;
            if (mem_rd_en && n_acc >= 4) extra_en++;
            if (rsp_cyc >= 0 && c == rsp_cyc + 1) begin
                check("busy_after_resp", fill_busy, 1'b0);
                check("rsp_addr_held", fill_rsp.address, v.exp_base);
                done = 1;
                fill_req.valid    = 1'b0;
                mem_rd_ready      = 1'b0;
                mem_rd_data_valid = 1'b0;
            end else begin
                rdy = v.rdy[(c - 1) % 8];
                mem_rd_ready = rdy;
                if (mem_rd_en && rdy && n_acc < 4) begin
                    check("rd_addr", mem_rd_addr, v.exp_base + 32'(4 * n_acc));
                    d = c + int'(v.lat[n_acc]);
                    if (d <= last_due) d = last_due + 1;
                    due[n_acc] = d;
                    last_due   = d;
                    n_acc++;
                end
                if (n_ret < n_acc && due[n_ret] == c) begin
                    mem_rd_data_valid = 1'b1;
                    mem_rd_data       = v.data[n_ret];
                    last_ret          = c;
                    n_ret++;
                end else begin
                    mem_rd_data_valid = 1'b0;
                    mem_rd_data       = $urandom;
                end
                if (v.alt_addr != 0) fill_req.fill_requested_address = v.alt_addr;
                prev_en   = mem_rd_en;
                prev_rdy  = rdy;
                prev_addr = mem_rd_addr;
            end
        end
        if (!done) check("fill_timeout", 1'b0, 1'b1);
        check("rsp_valid_cycles", rsp_cnt, 1);
        check("rd_accepts", n_acc, 4);
        check("rsp_after_last_return", rsp_cyc, last_ret + 1);
        if (v.exp_rsp_cyc != 0) check("rsp_latency", rsp_cyc, v.exp_rsp_cyc);
        check("rd_addr_hold", hold_bad, 0);
        check("rd_en_after_last", extra_en, 0);
    endtask

    // Idle cycles; optionally throws unsolicited return data at the engine.
    task automatic idle_cycles(input int n, input bit spurious);
        int busy_seen = 0;
        int rsp_seen  = 0;
        for (int k = 0; k < n; k++) begin
            @(negedge Clk);
            if (fill_busy || mem_rd_en) busy_seen++;
            if (fill_rsp.valid) rsp_seen++;
            mem_rd_data_valid = spurious;
            mem_rd_data       = 32'hBAD0_0000 + 32'(k);
        end
        @(negedge Clk);
        mem_rd_data_valid = 1'b0;
        check("idle_busy", busy_seen, 0);
        check("idle_rsp", rsp_seen, 0);
    endtask

    fill_vec_t vecs [6];
    fill_vec_t after_rst;

    initial begin
        vecs[0] = '{addr: 32'h0000_1238, alt_addr: 32'h0,
                    data: {32'hA3, 32'hA2, 32'hA1, 32'hA0}, lat: {8'd1, 8'd1, 8'd1, 8'd1},
                    rdy: 8'hFF, exp_base: 32'h0000_1230,
                    exp_line: 128'h000000A3_000000A2_000000A1_000000A0,
                    exp_rsp_cyc: 6, spurious_after: 0, b2b_next: 0};
        vecs[1] = '{addr: 32'h0000_5500, alt_addr: 32'h0,
                    data: {32'hB3B3_0003, 32'hB2B2_0002, 32'hB1B1_0001, 32'hB0B0_0000},
                    lat: {8'd1, 8'd1, 8'd1, 8'd1},
                    rdy: 8'hF2, exp_base: 32'h0000_5500,
                    exp_line: 128'hB3B30003_B2B20002_B1B10001_B0B00000,
                    exp_rsp_cyc: 9, spurious_after: 0, b2b_next: 0};
        vecs[2] = '{addr: 32'h0000_8A7C, alt_addr: 32'h0,
                    data: {32'hDEAD_BEEF, 32'h0123_4567, 32'h89AB_CDEF, 32'hFFFF_0000},
                    lat: {8'd10, 8'd2, 8'd7, 8'd1},
                    rdy: 8'hFF, exp_base: 32'h0000_8A70,
                    exp_line: 128'hDEADBEEF_01234567_89ABCDEF_FFFF0000,
                    exp_rsp_cyc: 15, spurious_after: 0, b2b_next: 0};
        vecs[3] = '{addr: 32'h0000_1234, alt_addr: 32'h0000_2000,
                    data: {32'hC3, 32'hC2, 32'hC1, 32'hC0}, lat: {8'd3, 8'd1, 8'd2, 8'd1},
                    rdy: 8'hFF, exp_base: 32'h0000_1230,
                    exp_line: 128'h000000C3_000000C2_000000C1_000000C0,
                    exp_rsp_cyc: 8, spurious_after: 1, b2b_next: 0};
        vecs[4] = '{addr: 32'h0000_2004, alt_addr: 32'h0,
                    data: {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111},
                    lat: {8'd1, 8'd1, 8'd1, 8'd1},
                    rdy: 8'hFF, exp_base: 32'h0000_2000,
                    exp_line: 128'h44444444_33333333_22222222_11111111,
                    exp_rsp_cyc: 6, spurious_after: 0, b2b_next: 1};
        vecs[5] = '{addr: 32'hFFFF_FFF0, alt_addr: 32'h0,
                    data: {32'h7777_0003, 32'h7777_0002, 32'h7777_0001, 32'h7777_0000},
                    lat: {8'd1, 8'd1, 8'd1, 8'd1},
                    rdy: 8'hAA, exp_base: 32'hFFFF_FFF0,
                    exp_line: 128'h77770003_77770002_77770001_77770000,
                    exp_rsp_cyc: 10, spurious_after: 0, b2b_next: 0};
        after_rst = '{addr: 32'h0000_4000, alt_addr: 32'h0,
                    data: {32'h6666_0004, 32'h6666_0003, 32'h6666_0002, 32'h6666_0001},
                    lat: {8'd1, 8'd1, 8'd1, 8'd1},
                    rdy: 8'hFF, exp_base: 32'h0000_4000,
                    exp_line: 128'h66660004_66660003_66660002_66660001,
                    exp_rsp_cyc: 6, spurious_after: 0, b2b_next: 0};

        Rst               = 1'b1;
        fill_req          = '0;
        mem_rd_ready      = 1'b0;
        mem_rd_data_valid = 1'b0;
        mem_rd_data       = '0;
        repeat (3) @(negedge Clk);
        Rst = 1'b0;
        @(negedge Clk);
        check("rst_rsp_valid", fill_rsp.valid, 1'b0);
        check("rst_rsp_addr", fill_rsp.address, 32'h0);
        check("rst_rsp_line", fill_rsp.filled_instruction, 128'h0);
        check("rst_rd_en", mem_rd_en, 1'b0);
        check("rst_rd_addr", mem_rd_addr, 32'h0);
        check("rst_busy", fill_busy, 1'b0);

        for (int i = 0; i < 6; i++) begin
            run_fill(vecs[i]);
            if (!vecs[i].b2b_next) idle_cycles(3, vecs[i].spurious_after);
        end

        // Reset after two returns; the two stale returns then land in IDLE.
        fill_req.fill_requested_address = 32'h0000_3008;
        fill_req.valid = 1'b1;
        mem_rd_ready   = 1'b1;
        @(negedge Clk);
        @(negedge Clk);
        mem_rd_data_valid = 1'b1; mem_rd_data = 32'h5555_0001;
        @(negedge Clk);
        mem_rd_data_valid = 1'b1; mem_rd_data = 32'h5555_0002;
        @(negedge Clk);
        check("pre_rst_busy", fill_busy, 1'b1);
        Rst = 1'b1; fill_req.valid = 1'b0; mem_rd_ready = 1'b0; mem_rd_data_valid = 1'b0;
        @(negedge Clk);
        Rst = 1'b0;
        check("midrst_busy", fill_busy, 1'b0);
        check("midrst_rd_en", mem_rd_en, 1'b0);
        check("midrst_rsp_valid", fill_rsp.valid, 1'b0);
        check("midrst_rsp_addr", fill_rsp.address, 32'h0);
        mem_rd_data_valid = 1'b1; mem_rd_data = 32'hDEAD_0003;
        @(negedge Clk);
        check("stale1_rsp_valid", fill_rsp.valid, 1'b0);
        mem_rd_data_valid = 1'b1; mem_rd_data = 32'hDEAD_0004;
        @(negedge Clk);
        check("stale2_rsp_valid", fill_rsp.valid, 1'b0);
        mem_rd_data_valid = 1'b0;
        @(negedge Clk);
        check("stale_busy", fill_busy, 1'b0);
        check("stale_rsp_valid", fill_rsp.valid, 1'b0);
        run_fill(after_rst);
        idle_cycles(2, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/ifu_line_fill.md
Name: ifu_line_fill

Overview:
- Fill engine between the instruction cache miss path and a 32-bit instruction memory read port.
- Accepts one cache-line fill request and aligns the address to the line.
- Issues CL_WIDTH/32 sequential word reads with back-pressure, collects the in-order returns into a full line, and delivers it to the cache as a single-cycle response.
- Sits directly downstream of the cache's WAIT_FOR_IMEM state.

Parameters:
- CL_WIDTH, 128, cache line width in bits; must be a multiple of WORD_WIDTH.
- WORD_WIDTH, 32, memory read data width.
- WORDS_PER_CL, CL_WIDTH/WORD_WIDTH (4), reads per fill; derived, not overridable.

Ports:
- Clk  in  1  clock; all logic is rising-edge.
- Rst  in  1  synchronous, active-high reset.
- FillReq  in  t_cache2i_mem_req  fill_requested_address[31:0] plus _valid from the cache.
- FillRsp  out  t_i_mem2cache_rsp  filled_instruction[CL_WIDTH-1:0], valid, address[31:0].
- MemRdEn  out  1  read request strobe to memory.
- MemRdAddr  out  32  word address of the read; bits[1:0] always 0.
- MemRdReady  in  1  memory accepts the read this cycle when MemRdEn && MemRdReady.
- MemRdDataValid  in  1  read data returned; returns are in order, latency ≥1, unbounded.
- MemRdData  in  WORD_WIDTH  returned word.
- FillBusy  out  1  high in every non-IDLE state.

Behaviour:
- Reset:
  - State goes to IDLE.
  - FillRsp.valid=0, FillRsp.address=0, FillRsp.filled_instruction=0.
  - MemRdEn=0, MemRdAddr=0, FillBusy=0.
  - Issue count, return count and line buffer are cleared.
- States:
  - IDLE:
    - When FillReq valid=1, latch base = {addr[31:$clog2(CL_WIDTH/8)], zeros} and move to FETCH.
    - Acceptance takes 1 cycle. MemRdEn is first asserted the cycle after the request is sampled.
  - FETCH:
    - MemRdEn=1 while issue_cnt<WORDS_PER_CL.
    - MemRdAddr = base + 4*issue_cnt.
    - issue_cnt increments only on MemRdEn&&MemRdReady. MemRdAddr is held stable while Ready=0.
    - Each MemRdDataValid writes MemRdData into line[WORD_WIDTH*ret_cnt +: WORD_WIDTH], then ret_cnt increments.
    - Returns may overlap issues, including a return in the same cycle as an issue.
    - Go to RESP when ret_cnt reaches WORDS_PER_CL-1 and MemRdDataValid=1 in that cycle.
  - RESP:
    - Exactly one cycle with FillRsp.valid=1, filled_instruction=line, address=base.
    - Then go to IDLE with counters cleared.
    - Request valid seen during RESP is ignored. The cache drops its request on seeing the response.
- Word order: word 0 (lowest address) goes in bits [31:0]; the highest address goes in the MSBs.
- Counters:
  - Width is $clog2(WORDS_PER_CL)+1.
  - Issue never exceeds WORDS_PER_CL, so MemRdEn drops the cycle after the last accepted read.
- FillReq changes while FillBusy=1 are ignored. The latched base is used to completion.
- MemRdDataValid in IDLE or RESP is dropped: no state change, no buffer write.
- Rst mid-fill:
  - Abandon immediately and go to IDLE; FillRsp.valid is not asserted for the abandoned line.
  - Late returns from that fill arrive in IDLE and are dropped.
  - If a new request is accepted before the stale returns drain, integrity is the memory side's responsibility: memory is reset together with Rst.
- FillRsp.filled_instruction and FillRsp.address are registered and hold their value after RESP.
  - Consumers qualify them with valid only.
- Minimum fill latency with Ready=1 and 1-cycle memory latency: request sampled at T, response valid at T+6.

Decomposition:
- In ifu_pkg: t_cache2i_mem_req and t_i_mem2cache_rsp (already present).
- Add to ifu_pkg:
  - enum t_fill_states {FILL_IDLE, FILL_FETCH, FILL_RESP}.
  - WORD_WIDTH.
  - WORDS_PER_CL = CL_WIDTH/WORD_WIDTH.
- No sub-module: the line buffer, the two counters and the FSM form one module.

Test Plan:
- Basic fill:
  - Stimulus: request addr 0x0000_1238, Ready=1, 1-cycle latency, data returns 0xA0,0xA1,0xA2,0xA3.
  - Required: reads to 0x1230,0x1234,0x1238,0x123C; one-cycle FillRsp.valid with address=0x1230 and line=0x000000A3_000000A2_000000A1_000000A0.
- Back-pressure:
  - Stimulus: Ready toggles 0,1,0,0,1,1,1.
  - Required: MemRdAddr held while Ready=0; exactly 4 accepted reads; correct line; MemRdEn=0 after the 4th accept.
- Long and variable latency:
  - Stimulus: returns at 1, 7, 2 and 10 cycles, in order.
  - Required: FillRsp.valid exactly one cycle after the 4th return is sampled; no early response.
- Busy interference:
  - Stimulus: FillReq.address changes to 0x2000 mid-fill; spurious MemRdDataValid in IDLE.
  - Required: the response still carries address 0x1230; the spurious data does not corrupt the next fill.
- Reset mid-fill:
  - Stimulus: Rst after 2 returns; 2 stale returns then arrive in IDLE; next request 0x4000.
  - Required: no response for the aborted fill; the 0x4000 fill completes with the correct data.
- Back-to-back:
  - Stimulus: a new request presented in the cycle after RESP.
  - Required: it is accepted immediately; the RESP-cycle request is not double-accepted.
